// File: rtl/hazard_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Brief    : ID-stage interlock for the 5-stage RISC-V pipeline. Keeps a
//             per-register scoreboard of in-flight loads (fixed latency) and
//             multi-cycle MUL/DIV results (completion tagged). Raises stall
//             on RAW, WAW and long-unit structural hazards, drives the ID/EX
//             bubble, and keeps a saturating stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int LOAD_LAT = 1,
    parameter  int CNT_W    = 32,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs1,
    input  logic             id_rs1_used,
    input  logic [AW-1:0]    id_rs2,
    input  logic             id_rs2_used,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             id_is_long,
    input  logic             flush,
    input  logic             long_done,
    input  logic [AW-1:0]    long_done_rd,
    output logic             stall,
    output logic             bubble,
    output logic             long_busy,
    output logic [CNT_W-1:0] stall_count
);

    // Scoreboard is sized to the full index space so that any AW-bit index
    // selects a defined entry; indices at or above NUM_REGS never hazard.
    localparam int c_depth = 1 << AW;

    // Load countdown start value, kept inside the 3-bit counter range.
    localparam int           c_lat_clamped = (LOAD_LAT < 1) ? 1 :
                                             (LOAD_LAT > 7) ? 7 : LOAD_LAT;
    localparam logic [2:0]   c_ld_init     = 3'(c_lat_clamped);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    // Per-register views exported from the scoreboard entries
    logic [c_depth-1:0] w_busy;      // register cannot be read this cycle
    logic [c_depth-1:0] w_lp_pend;   // long result still pending, not bypassed

    // Hazard terms and issue qualifier
    logic w_raw;
    logic w_waw;
    logic w_strc;
    logic w_stall;
    logic w_issue;

    // Long unit occupancy and performance counter
    logic             r_long_out;
    logic [CNT_W-1:0] r_stall_count;

    // ------------------------------------------------------------------------
    // Per-register scoreboard entries
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_depth; gi++) begin : g_reg
            if (gi == 0 || gi >= NUM_REGS) begin : g_tied
                // x0 is hardwired and out-of-range indices have no storage
                assign w_busy[gi]    = 1'b0;
                assign w_lp_pend[gi] = 1'b0;
            end else begin : g_live
                localparam logic [AW-1:0] c_idx = AW'(gi);

                logic [2:0] r_ld_cnt;   // cycles left before a load result is usable
                logic       r_lp;       // long-unit result outstanding for this register
                logic       w_done_hit; // long-unit writes this register now
                logic       w_ld_set;   // a load targeting this register issues now
                logic       w_lp_set;   // a long op targeting this register issues now

                assign w_done_hit = long_done & (long_done_rd == c_idx);
                assign w_ld_set   = w_issue & id_is_load & id_reg_write & (id_rd == c_idx);
                assign w_lp_set   = w_issue & id_is_long & id_reg_write & (id_rd == c_idx);

                // Load countdown: a fresh load reloads it, otherwise it drains to zero
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_ld_cnt <= 3'd0;
                    end else if (w_ld_set) begin
                        r_ld_cnt <= c_ld_init;
                    end else if (r_ld_cnt != 3'd0) begin
                        r_ld_cnt <= r_ld_cnt - 3'd1;
                    end
                end

                // Long-pending flag: a new long op wins over a completing one
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_lp <= 1'b0;
                    end else if (w_lp_set) begin
                        r_lp <= 1'b1;
                    end else if (w_done_hit) begin
                        r_lp <= 1'b0;
                    end
                end

                // The writeback of a completing long op is forwarded through
                // the register file, so it no longer blocks readers or writers.
                assign w_lp_pend[gi] = r_lp & ~w_done_hit;
                assign w_busy[gi]    = (r_ld_cnt != 3'd0) | w_lp_pend[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    assign w_raw   = (id_rs1_used & w_busy[id_rs1]) |
                     (id_rs2_used & w_busy[id_rs2]);
    // Only long results can land out of order, so only they create WAW;
    // w_lp_pend is tied low for x0.
    assign w_waw   = id_reg_write & w_lp_pend[id_rd];
    // The long unit is not pipelined: a second long op waits for the first
    // to complete, but may enter on the completion cycle itself.
    assign w_strc  = id_is_long & r_long_out & ~long_done;

    // A flushed instruction is discarded, so it must never hold the front end.
    assign w_stall = id_valid & ~flush & (w_raw | w_waw | w_strc);
    assign w_issue = id_valid & ~w_stall & ~flush;

    // Long unit occupancy: a new issue wins over a completion in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_long_out <= 1'b0;
        end else if (w_issue & id_is_long) begin
            r_long_out <= 1'b1;
        end else if (long_done) begin
            r_long_out <= 1'b0;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != c_cnt_max)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall       = w_stall;
    assign bubble      = w_stall | flush;
    assign long_busy   = r_long_out;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_scoreboard
//  Brief    : Self-checking bench for hazard_scoreboard. Two instances share
//             the ID-stage inputs: A (LOAD_LAT=1, 32-bit counter) and
//             B (LOAD_LAT=3, 4-bit counter). Directed vector table, directed
//             reset and saturation sequences, then random traffic against a
//             cycle-indexed reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic       id_rs1_used;
    logic [4:0] id_rs2;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_long;
    logic       flush;
    logic       long_done;
    logic [4:0] long_done_rd;

    logic        stall_a, bubble_a, busy_a;
    logic [31:0] cnt_a;
    logic        stall_b, bubble_b, busy_b;
    logic [3:0]  cnt_b;

    hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_long(id_is_long), .flush(flush),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .stall(stall_a), .bubble(bubble_a), .long_busy(busy_a), .stall_count(cnt_a)
    );

    hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .id_is_long(id_is_long), .flush(flush),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .stall(stall_b), .bubble(bubble_b), .long_busy(busy_b), .stall_count(cnt_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld, input logic lg, input logic fl,
                         input logic dn, input logic [4:0] dnrd);
        id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_reg_write = we; id_is_load = ld; id_is_long = lg;
        flush = fl; long_done = dn; long_done_rd = dnrd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table: one record per cycle
    // ------------------------------------------------------------------------
    typedef struct {
        logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic we; logic ld; logic lg; logic fl; logic dn; logic [4:0] dnrd;
        logic sa; logic ba; logic sb; logic bb; logic busy; int ca; int cb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic lg, input logic fl,
                       input logic dn, input logic [4:0] dnrd,
                       input logic sa, input logic ba, input logic sb, input logic bb,
                       input logic busy, input int ca, input int cb);
        vec_t t;
        t = '{v, rs1, u1, rs2, u2, rd, we, ld, lg, fl, dn, dnrd, sa, ba, sb, bb, busy, ca, cb};
        tbl.push_back(t);
    endtask

    task automatic build_table();
        //   v rs1 u1 rs2 u2 rd we ld lg fl dn dnrd | sa ba sb bb busy ca cb
        // lw x5 ; add x6,x5,x7
        add(1, 0,0, 0,0, 5,1,1,0,0,0,0,  0,0,0,0,0, 0,0);
        add(1, 5,1, 7,1, 6,1,0,0,0,0,0,  1,1,1,1,0, 0,0);
        add(1, 5,1, 7,1, 6,1,0,0,0,0,0,  0,0,1,1,0, 1,1);
        add(1, 5,1, 7,1, 6,1,0,0,0,0,0,  0,0,1,1,0, 1,2);
        add(1, 5,1, 7,1, 6,1,0,0,0,0,0,  0,0,0,0,0, 1,3);
        // lw x5 ; reader through rs2 only
        add(1, 0,0, 0,0, 5,1,1,0,0,0,0,  0,0,0,0,0, 1,3);
        add(1, 5,0, 5,1, 6,1,0,0,0,0,0,  1,1,1,1,0, 1,3);
        add(1, 5,0, 5,1, 6,1,0,0,0,0,0,  0,0,1,1,0, 2,4);
        add(1, 5,0, 5,1, 6,1,0,0,0,0,0,  0,0,1,1,0, 2,5);
        add(1, 5,0, 5,1, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,6);
        // lw x0 ; reader of x0
        add(1, 0,0, 0,0, 0,1,1,0,0,0,0,  0,0,0,0,0, 2,6);
        add(1, 0,1, 0,1, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,6);
        // flushed lw x5 sets nothing ; flushed reader of a live load
        add(1, 0,0, 0,0, 5,1,1,0,1,0,0,  0,1,0,1,0, 2,6);
        add(1, 5,1, 0,0, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,6);
        add(1, 0,0, 0,0, 5,1,1,0,0,0,0,  0,0,0,0,0, 2,6);
        add(1, 5,1, 0,0, 6,1,0,0,1,0,0,  0,1,0,1,0, 2,6);
        add(1, 5,1, 0,0, 6,1,0,0,0,0,0,  0,0,1,1,0, 2,6);
        add(1, 5,1, 0,0, 6,1,0,0,0,0,0,  0,0,1,1,0, 2,7);
        add(1, 5,1, 0,0, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,8);
        // source-used and valid gating
        add(1, 0,0, 0,0, 5,1,1,0,0,0,0,  0,0,0,0,0, 2,8);
        add(1, 5,0, 3,1, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,8);
        add(0, 5,1, 0,0, 6,1,0,0,0,0,0,  0,0,0,0,0, 2,8);
        add(0, 0,0, 0,0, 0,0,0,0,0,0,0,  0,0,0,0,0, 2,8);
        add(0, 0,0, 0,0, 0,0,0,0,0,0,0,  0,0,0,0,0, 2,8);
        // div x8 ; reader of x8 until long_done(8)
        add(1, 0,0, 0,0, 8,1,0,1,0,0,0,  0,0,0,0,0, 2,8);
        add(1, 8,1, 0,0, 6,1,0,0,0,0,0,  1,1,1,1,1, 2,8);
        add(1, 8,1, 0,0, 6,1,0,0,0,0,0,  1,1,1,1,1, 3,9);
        add(1, 8,1, 0,0, 6,1,0,0,0,1,8,  0,0,0,0,1, 4,10);
        // div x9 ; div x10 waits on the unit ; add x10 waits on WAW
        add(1, 0,0, 0,0, 9,1,0,1,0,0,0,  0,0,0,0,0, 4,10);
        add(1, 0,0, 0,0,10,1,0,1,0,0,0,  1,1,1,1,1, 4,10);
        add(1, 0,0, 0,0,10,1,0,1,0,0,0,  1,1,1,1,1, 5,11);
        add(1, 0,0, 0,0,10,1,0,1,0,1,9,  0,0,0,0,1, 6,12);
        add(1, 0,0, 0,0,10,1,0,0,0,0,0,  1,1,1,1,1, 6,12);
        add(1, 0,0, 0,0,10,1,0,0,0,1,10, 0,0,0,0,1, 7,13);
        add(0, 0,0, 0,0, 0,0,0,0,0,0,0,  0,0,0,0,0, 7,13);
        // div x0 occupies the unit only ; stray long_done just frees it
        add(1, 0,0, 0,0, 0,1,0,1,0,0,0,  0,0,0,0,0, 7,13);
        add(1, 0,1, 0,1, 6,1,0,0,0,0,0,  0,0,0,0,1, 7,13);
        add(0, 0,0, 0,0, 0,0,0,0,0,1,12, 0,0,0,0,1, 7,13);
        add(0, 0,0, 0,0, 0,0,0,0,0,0,0,  0,0,0,0,0, 7,13);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: cycle-indexed readiness times and pending sets
    // ------------------------------------------------------------------------
    int     lat[2]  = '{1, 3};
    longint cmax[2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
    int     cyc;
    int     ld_ready[2][32];  // first cycle a reader of r may issue
    bit     pend[2][32];
    bit     lout[2];
    longint cntm[2];

    task automatic m_reset();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            lout[i] = 1'b0;
            cntm[i] = 0;
            for (int r = 0; r < 32; r++) begin
                ld_ready[i][r] = 0;
                pend[i][r]     = 1'b0;
            end
        end
    endtask

    function automatic bit m_wb(int r);
        return long_done && (int'(long_done_rd) == r);
    endfunction

    function automatic bit m_busy(int i, int r);
        if (r == 0) return 1'b0;
        if (cyc < ld_ready[i][r]) return 1'b1;
        return pend[i][r] && !m_wb(r);
    endfunction

    function automatic bit m_stall(int i);
        bit raw, waw, strc;
        raw  = (id_rs1_used && m_busy(i, int'(id_rs1))) ||
               (id_rs2_used && m_busy(i, int'(id_rs2)));
        waw  = id_reg_write && (id_rd != 0) && pend[i][id_rd] && !m_wb(int'(id_rd));
        strc = id_is_long && lout[i] && !long_done;
        return id_valid && !flush && (raw || waw || strc);
    endfunction

    task automatic m_clock();
        for (int i = 0; i < 2; i++) begin
            bit st, iss;
            st  = m_stall(i);
            iss = id_valid && !st && !flush;
            if (st && cntm[i] < cmax[i]) cntm[i]++;
            if (long_done) begin
                pend[i][long_done_rd] = 1'b0;
                lout[i] = 1'b0;
            end
            if (iss && id_is_load && id_reg_write && id_rd != 0)
                ld_ready[i][id_rd] = cyc + lat[i] + 1;
            if (iss && id_is_long && id_reg_write && id_rd != 0)
                pend[i][id_rd] = 1'b1;
            if (iss && id_is_long)
                lout[i] = 1'b1;
        end
        cyc++;
    endtask

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        // Hazard-looking inputs during reset must not stall
        drive(1, 5, 1, 8, 1, 8, 1, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall_a",  stall_a,  0);  chk("rst_stall_b",  stall_b,  0);
        chk("rst_bubble_a", bubble_a, 0);  chk("rst_bubble_b", bubble_b, 0);
        chk("rst_busy_a",   busy_a,   0);  chk("rst_busy_b",   busy_b,   0);
        chk("rst_cnt_a",    cnt_a,    0);  chk("rst_cnt_b",    cnt_b,    0);
        idle();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        build_table();
        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].rs1, tbl[k].u1, tbl[k].rs2, tbl[k].u2, tbl[k].rd,
                  tbl[k].we, tbl[k].ld, tbl[k].lg, tbl[k].fl, tbl[k].dn, tbl[k].dnrd);
            @(negedge clk);
            chk($sformatf("row%0d_stall_a", k),  stall_a,  tbl[k].sa);
            chk($sformatf("row%0d_bubble_a", k), bubble_a, tbl[k].ba);
            chk($sformatf("row%0d_stall_b", k),  stall_b,  tbl[k].sb);
            chk($sformatf("row%0d_bubble_b", k), bubble_b, tbl[k].bb);
            chk($sformatf("row%0d_busy_a", k),   busy_a,   tbl[k].busy);
            chk($sformatf("row%0d_busy_b", k),   busy_b,   tbl[k].busy);
            chk($sformatf("row%0d_cnt_a", k),    cnt_a,    tbl[k].ca);
            chk($sformatf("row%0d_cnt_b", k),    cnt_b,    tbl[k].cb);
            @(posedge clk); #1;
        end

        // Reset asserted while B is stalled on a load
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_stall_a1", stall_a, 1);  chk("mid_stall_b1", stall_b, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_stall_a2", stall_a, 0);  chk("mid_stall_b2", stall_b, 1);
        chk("mid_cnt_a2",   cnt_a,   1);  chk("mid_cnt_b2",   cnt_b,   1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall_b",  stall_b,  0);  chk("arst_bubble_b", bubble_b, 0);
        chk("arst_cnt_a",    cnt_a,    0);  chk("arst_cnt_b",    cnt_b,    0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("post_rst_stall_a", stall_a, 0);  chk("post_rst_stall_b", stall_b, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_stall_b2", stall_b, 0);  chk("post_rst_cnt_b", cnt_b, 0);

        // Counter saturation: B's 4-bit counter pins at 15, A keeps counting
        do_reset();
        drive(1, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 8, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sat_stall_b", stall_b, 1);
        chk("sat_cnt_a",   cnt_a,  20);
        chk("sat_cnt_b",   cnt_b,  15);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sat_hold_b",  cnt_b,  15);
        chk("sat_cnt_a2",  cnt_a,  21);
        drive(1, 8, 1, 0, 0, 6, 1, 0, 0, 0, 1, 8);
        @(negedge clk);
        chk("sat_release_a", stall_a, 0);  chk("sat_release_b", stall_b, 0);
        @(posedge clk); #1;

        // Random traffic against the reference model
        do_reset();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            int kind;
            kind         = int'($urandom_range(0, 5));
            id_valid     = ($urandom_range(0, 9) < 8);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs1_used  = ($urandom_range(0, 3) != 0);
            id_rs2       = 5'($urandom_range(0, 7));
            id_rs2_used  = ($urandom_range(0, 3) != 0);
            id_rd        = 5'($urandom_range(0, 7));
            id_reg_write = ($urandom_range(0, 4) != 0);
            id_is_load   = (kind < 2);
            id_is_long   = (kind == 2);
            flush        = ($urandom_range(0, 9) == 0);
            long_done    = ($urandom_range(0, 3) == 0);
            long_done_rd = 5'($urandom_range(0, 7));
            @(negedge clk);
            chk("rnd_stall_a",  stall_a,  m_stall(0));
            chk("rnd_stall_b",  stall_b,  m_stall(1));
            chk("rnd_bubble_a", bubble_a, m_stall(0) | flush);
            chk("rnd_bubble_b", bubble_b, m_stall(1) | flush);
            chk("rnd_busy_a",   busy_a,   lout[0]);
            chk("rnd_busy_b",   busy_b,   lout[1]);
            chk("rnd_cnt_a",    cnt_a,    cntm[0]);
            chk("rnd_cnt_b",    cnt_b,    cntm[1]);
            @(posedge clk);
            m_clock();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
